// File: rtl/branch_predictor.sv
// Branch target buffer with 2-bit saturating direction counters: combinational
// next-PC prediction at IF, table training and registered redirect at ID resolve.
module branch_predictor #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ENTRY_NUM  = 16,
    parameter int unsigned PERF_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] lookup_pc,
    output logic                  pred_taken,
    output logic [ADDR_WIDTH-1:0] pred_target,
    input  logic                  upd_valid,
    input  logic                  upd_is_cti,
    input  logic [ADDR_WIDTH-1:0] upd_pc,
    input  logic                  upd_taken,
    input  logic [ADDR_WIDTH-1:0] upd_target,
    input  logic                  upd_pred_taken,
    input  logic [ADDR_WIDTH-1:0] upd_pred_target,
    output logic                  mispredict,
    output logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic [PERF_WIDTH-1:0] perf_cti,
    output logic [PERF_WIDTH-1:0] perf_miss
);

    localparam int unsigned INDEX_W = $clog2(ENTRY_NUM);
    localparam int unsigned TAG_W   = ADDR_WIDTH - INDEX_W - 2;

    logic                  valid_q  [ENTRY_NUM];
    logic [TAG_W-1:0]      tag_q    [ENTRY_NUM];
    logic [ADDR_WIDTH-1:0] target_q [ENTRY_NUM];
    logic [1:0]            ctr_q    [ENTRY_NUM];

    logic                  mispredict_q, mispredict_d;
    logic [ADDR_WIDTH-1:0] redirect_q, redirect_d;
    logic [PERF_WIDTH-1:0] perf_cti_q, perf_cti_d;
    logic [PERF_WIDTH-1:0] perf_miss_q, perf_miss_d;

    logic [INDEX_W-1:0]    lk_idx, up_idx;
    logic [TAG_W-1:0]      lk_tag, up_tag;
    logic                  lk_hit, up_hit;

    logic                  taken_eff_c;
    logic                  miss_c;
    logic                  cti_c;
    logic                  tbl_we_c;
    logic [1:0]            cur_ctr_c;
    logic [1:0]            wr_ctr_c;
    logic [ADDR_WIDTH-1:0] wr_target_c;

    // Low PC bits address bytes within a word and never reach the table.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign lk_idx = lookup_pc[INDEX_W+1:2];
    assign lk_tag = lookup_pc[ADDR_WIDTH-1:INDEX_W+2];
    assign up_idx = upd_pc[INDEX_W+1:2];
    assign up_tag = upd_pc[ADDR_WIDTH-1:INDEX_W+2];

    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // Prediction reads registered state only; same-cycle updates are not bypassed.
    assign pred_taken  = lk_hit && ctr_q[lk_idx][1];
    assign pred_target = pred_taken ? target_q[lk_idx] : lookup_pc + ADDR_WIDTH'(4);

    always_comb begin
        taken_eff_c  = upd_is_cti & upd_taken;
        cti_c        = upd_valid & upd_is_cti;
        miss_c       = upd_valid & ((taken_eff_c != upd_pred_taken) |
                                    (taken_eff_c & (upd_target != upd_pred_target)));
        cur_ctr_c    = ctr_q[up_idx];
        tbl_we_c     = 1'b0;
        wr_ctr_c     = cur_ctr_c;
        wr_target_c  = target_q[up_idx];

        if (cti_c) begin
            if (up_hit) begin
                tbl_we_c = 1'b1;
                if (upd_taken) begin
                    wr_target_c = upd_target;
                    if (cur_ctr_c != 2'b11) wr_ctr_c = cur_ctr_c + 2'd1;
                end else if (cur_ctr_c != 2'b00) begin
                    wr_ctr_c = cur_ctr_c - 2'd1;
                end
            end else if (upd_taken) begin
                tbl_we_c    = 1'b1;
                wr_target_c = upd_target;
                wr_ctr_c    = 2'b10;
            end
        end else if (miss_c && up_hit) begin
            // A non-CTI predicted taken through an alias weakens that entry.
            tbl_we_c = 1'b1;
            if (cur_ctr_c != 2'b00) wr_ctr_c = cur_ctr_c - 2'd1;
        end

        mispredict_d = miss_c;
        redirect_d   = redirect_q;
        if (miss_c) redirect_d = taken_eff_c ? upd_target : upd_pc + ADDR_WIDTH'(4);

        perf_cti_d  = perf_cti_q;
        perf_miss_d = perf_miss_q;
        if (cti_c && (perf_cti_q != '1))   perf_cti_d  = perf_cti_q + PERF_WIDTH'(1);
        if (miss_c && (perf_miss_q != '1)) perf_miss_d = perf_miss_q + PERF_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (tbl_we_c) begin
            valid_q[up_idx]  <= 1'b1;
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= wr_target_c;
            ctr_q[up_idx]    <= wr_ctr_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
            perf_cti_q   <= '0;
            perf_miss_q  <= '0;
        end else begin
            mispredict_q <= mispredict_d;
            redirect_q   <= redirect_d;
            perf_cti_q   <= perf_cti_d;
            perf_miss_q  <= perf_miss_d;
        end
    end

    assign mispredict    = mispredict_q;
    assign redirect_addr = redirect_q;
    assign perf_cti      = perf_cti_q;
    assign perf_miss     = perf_miss_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0;
    logic        upd_is_cti = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_pred_taken = 1'b0;
    logic [31:0] upd_pred_target = '0;
    logic        mispredict;
    logic [31:0] redirect_addr;
    logic [3:0]  perf_cti;
    logic [3:0]  perf_miss;

    branch_predictor #(
        .ADDR_WIDTH(32),
        .ENTRY_NUM (16),
        .PERF_WIDTH(4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .lookup_pc      (lookup_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_valid      (upd_valid),
        .upd_is_cti     (upd_is_cti),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_pred_taken (upd_pred_taken),
        .upd_pred_target(upd_pred_target),
        .mispredict     (mispredict),
        .redirect_addr  (redirect_addr),
        .perf_cti       (perf_cti),
        .perf_miss      (perf_miss)
    );

    always #5 clk = ~clk;

    localparam int K_PT = 0, K_TGT = 1, K_MIS = 2, K_RED = 3, K_CTI = 4, K_MISS = 5;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] exp;
    } chk_t;

    chk_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    string kname [6] = '{"pred_taken", "pred_target", "mispredict",
                         "redirect_addr", "perf_cti", "perf_miss"};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int k);
        case (k)
            K_PT:    return {31'd0, pred_taken};
            K_TGT:   return pred_target;
            K_MIS:   return {31'd0, mispredict};
            K_RED:   return redirect_addr;
            K_CTI:   return {28'd0, perf_cti};
            default: return {28'd0, perf_miss};
        endcase
    endfunction

    // Monitor: compare every expectation stamped for the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            chk_t e;
            logic [31:0] a;
            e = sb.pop_front();
            checks++;
            if (e.cyc < cyc) begin
                $display("FAIL stale_%s cyc=%0d: check for cyc %0d never sampled", kname[e.kind], cyc, e.cyc);
            end else begin
                a = actual(e.kind);
                if (a === e.exp) passed++;
                else $display("FAIL %s cyc=%0d: got %h expected %h", kname[e.kind], cyc, a, e.exp);
            end
        end
    end

    task automatic ex(input int dc, input int kind, input logic [31:0] v);
        chk_t e;
        e.cyc  = cyc + dc;
        e.kind = kind;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [31:0] lpc, input logic uv, input logic cti,
                         input logic [31:0] upc, input logic ut, input logic [31:0] utg,
                         input logic upt, input logic [31:0] uptg);
        lookup_pc       = lpc;
        upd_valid       = uv;
        upd_is_cti      = cti;
        upd_pc          = upc;
        upd_taken       = ut;
        upd_target      = utg;
        upd_pred_taken  = upt;
        upd_pred_target = uptg;
    endtask

    task automatic idle(input logic [31:0] lpc);
        drive(lpc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        rst_n = 1'b1;

        // Cold start
        idle(32'h0040_0010);
        ex(0, K_PT, 0); ex(0, K_TGT, 32'h0040_0014); ex(0, K_MIS, 0);
        ex(0, K_CTI, 0); ex(0, K_MISS, 0);
        tick();

        // Allocation, with same-cycle lookup seeing old contents
        drive(32'h0040_0010, 1, 1, 32'h0040_0010, 1, 32'h0040_0100, 0, 32'h0040_0014);
        ex(0, K_PT, 0); ex(0, K_TGT, 32'h0040_0014);
        ex(1, K_MIS, 1); ex(1, K_RED, 32'h0040_0100); ex(1, K_CTI, 1); ex(1, K_MISS, 1);
        tick();
        idle(32'h0040_0010);
        ex(0, K_PT, 1); ex(0, K_TGT, 32'h0040_0100); ex(1, K_MIS, 0);
        tick();

        // Aliasing on index 4
        idle(32'h0040_0050);
        ex(0, K_PT, 0); ex(0, K_TGT, 32'h0040_0054);
        tick();
        drive(32'h0040_0010, 1, 1, 32'h0040_0050, 1, 32'h0040_0200, 0, 32'h0040_0054);
        ex(0, K_PT, 1);
        ex(1, K_MIS, 1); ex(1, K_RED, 32'h0040_0200); ex(1, K_CTI, 2); ex(1, K_MISS, 2);
        tick();
        idle(32'h0040_0010);
        ex(0, K_PT, 0); ex(0, K_TGT, 32'h0040_0014); ex(1, K_MIS, 0);
        tick();
        idle(32'h0040_0050);
        ex(0, K_PT, 1); ex(0, K_TGT, 32'h0040_0200);
        tick();

        // Hysteresis: 10 -> 01 -> 00 -> 01
        drive(32'h0040_0050, 1, 1, 32'h0040_0050, 0, 32'h0, 1, 32'h0040_0200);
        ex(0, K_PT, 1);
        ex(1, K_MIS, 1); ex(1, K_RED, 32'h0040_0054); ex(1, K_CTI, 3); ex(1, K_MISS, 3);
        tick();
        drive(32'h0040_0050, 1, 1, 32'h0040_0050, 0, 32'h0, 0, 32'h0040_0054);
        ex(0, K_PT, 0);
        ex(1, K_MIS, 0); ex(1, K_CTI, 4); ex(1, K_MISS, 3);
        tick();
        drive(32'h0040_0050, 1, 1, 32'h0040_0050, 1, 32'h0040_0200, 0, 32'h0040_0054);
        ex(1, K_MIS, 1); ex(1, K_RED, 32'h0040_0200); ex(1, K_CTI, 5); ex(1, K_MISS, 4);
        tick();
        idle(32'h0040_0050);
        ex(0, K_PT, 0); ex(0, K_TGT, 32'h0040_0054); ex(1, K_MIS, 0);
        tick();

        // Wrap of fall-through address
        idle(32'hFFFF_FFFC);
        ex(0, K_PT, 0); ex(0, K_TGT, 32'h0000_0000);
        tick();

        // Non-CTI predicted taken: mispredict, decrement 01 -> 00, no CTI count
        drive(32'h0040_0050, 1, 0, 32'h0040_0050, 1, 32'h0040_0200, 1, 32'h0040_0200);
        ex(1, K_MIS, 1); ex(1, K_RED, 32'h0040_0054); ex(1, K_CTI, 5); ex(1, K_MISS, 5);
        tick();
        drive(32'h0040_0050, 1, 1, 32'h0040_0050, 1, 32'h0040_0200, 0, 32'h0040_0054);
        ex(1, K_MIS, 1); ex(1, K_RED, 32'h0040_0200); ex(1, K_CTI, 6); ex(1, K_MISS, 6);
        tick();
        idle(32'h0040_0050);
        ex(0, K_PT, 0);
        tick();
        drive(32'h0040_0050, 1, 0, 32'h0040_0050, 0, 32'h0, 0, 32'h0);
        ex(1, K_MIS, 0); ex(1, K_CTI, 6); ex(1, K_MISS, 6);
        tick();

        // Miss counter saturation (4-bit): 6 + 12 clamps at 15
        for (int i = 0; i < 12; i++) begin
            drive(32'h0, 1, 0, 32'h0040_0080, 0, 32'h0, 1, 32'h0040_0100);
            tick();
        end
        drive(32'h0040_0050, 1, 1, 32'h0040_0050, 1, 32'h0040_0200, 0, 32'h0040_0054);
        ex(0, K_MIS, 1); ex(0, K_RED, 32'h0040_0084); ex(0, K_CTI, 6); ex(0, K_MISS, 15);
        ex(1, K_MIS, 1); ex(1, K_CTI, 7); ex(1, K_MISS, 15);
        tick();
        idle(32'h0040_0050);
        ex(0, K_PT, 1); ex(0, K_TGT, 32'h0040_0200);
        tick();

        // Asynchronous reset mid-stream, checked before any further clock edge
        drive(32'h0040_0050, 1, 1, 32'h0040_0050, 1, 32'h0040_0300, 0, 32'h0040_0054);
        rst_n = 1'b0;
        ex(0, K_PT, 0); ex(0, K_TGT, 32'h0040_0054); ex(0, K_MIS, 0);
        ex(0, K_RED, 0); ex(0, K_CTI, 0); ex(0, K_MISS, 0);
        tick();
        tick();
        idle(32'h0040_0050);
        rst_n = 1'b1;
        tick();
        idle(32'h0040_0050);
        ex(0, K_PT, 0); ex(0, K_MIS, 0); ex(0, K_CTI, 0);
        tick();

        repeat (20) begin
            if (sb.size() == 0) break;
            tick();
        end
        if (sb.size() != 0) begin
            checks += sb.size();
            $display("FAIL drain: got %0d unchecked entries expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch target buffer with 2-bit saturating direction counters. It generalises the decode-stage branch resolver into a predict-then-resolve pair. During IF it predicts next-PC from the current PC. When ID resolves a control transfer, it trains the table, flags mispredictions one cycle later with a redirect address, and keeps saturating performance counters.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: PC and target width.
- `ENTRY_NUM`, 16: BTB entries; must be a power of two, 2..1024. `INDEX_W = log2(ENTRY_NUM)`, `TAG_W = ADDR_WIDTH - INDEX_W - 2`.
- `PERF_WIDTH`, 32: width of each performance counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `lookup_pc` in ADDR_WIDTH: IF-stage PC.
- `pred_taken` out 1: prediction is taken.
- `pred_target` out ADDR_WIDTH: predicted next PC.
- `upd_valid` in 1: ID presents a resolved instruction this cycle.
- `upd_is_cti` in 1: the resolved instruction is a branch or jump.
- `upd_pc` in ADDR_WIDTH: PC of the resolved instruction.
- `upd_taken` in 1: actual direction (the resolver's branch flag).
- `upd_target` in ADDR_WIDTH: actual target (the resolver's branch address).
- `upd_pred_taken` in 1: prediction that was made for this instruction, carried down the pipe.
- `upd_pred_target` in ADDR_WIDTH: predicted target carried down the pipe.
- `mispredict` out 1: registered; the previous update was mispredicted.
- `redirect_addr` out ADDR_WIDTH: registered; correct fetch address when `mispredict` is 1.
- `perf_cti` out PERF_WIDTH: count of resolved control-transfer instructions.
- `perf_miss` out PERF_WIDTH: count of mispredictions.

## Operation
- **Address split:** index = `pc[INDEX_W+1:2]`; tag = `pc[ADDR_WIDTH-1:INDEX_W+2]`. `pc[1:0]` is ignored.
- **Entry contents:** valid bit, tag, target, 2-bit counter. Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- **Lookup (combinational from state):** hit = valid & tag match.
  - Hit with `counter[1]` set: `pred_taken` = 1, `pred_target` = stored target.
  - Otherwise: `pred_taken` = 0, `pred_target` = `lookup_pc + 4`, wrapping modulo 2^ADDR_WIDTH.
- **Update:** applied at the clock edge when `upd_valid` and `upd_is_cti` are both 1.
  - Hit, taken: counter increments, saturating at 11; target is overwritten with `upd_target`.
  - Hit, not taken: counter decrements, saturating at 00; target is unchanged.
  - Miss, taken: allocate the entry (valid = 1, new tag, `upd_target`, counter 10), overwriting any alias.
  - Miss, not taken: no change.
- **Non-CTI updates:** `upd_valid` with `upd_is_cti` = 0 causes no table change and no count. It can still raise `mispredict` if a non-CTI was predicted taken after aliasing. In that case the entry's counter decrements if its tag matches.
- **Misprediction condition:** `upd_valid` & (`upd_taken` ≠ `upd_pred_taken` | (`upd_taken` & `upd_target` ≠ `upd_pred_target`)). `upd_taken` is treated as 0 when `upd_is_cti` = 0.
- **Redirect:** `redirect_addr` = `upd_target` if taken, else `upd_pc + 4`.
- **Performance counters:**
  - `perf_cti` increments on each CTI update.
  - `perf_miss` increments on each misprediction.
  - Both saturate at all-ones and do not wrap.

## Timing
- Lookup has zero-cycle latency and is combinational from `lookup_pc` and registered state.
- Table updates become visible to lookup in the cycle after the edge. A same-cycle lookup of the index being updated returns the pre-update contents; there is no bypass.
- `mispredict` and `redirect_addr` are registered. They are valid in the cycle after the update and de-assert the next cycle unless a new mispredict occurs. There is no stall or hold.
- Reset is asynchronous:
  - Clears all valid bits and sets all counters to 01; tags and targets are cleared to 0.
  - `mispredict` = 0, `redirect_addr` = 0, `perf_cti` = 0, `perf_miss` = 0.
  - After reset, `pred_taken` = 0 and `pred_target` = `lookup_pc + 4`.
- Reset asserted mid-operation discards any update in flight; the first edge after release performs no update unless `upd_valid` is 1.

## Test plan
Scenarios use ADDR_WIDTH = 32 and ENTRY_NUM = 16.
1. **Cold start:** reset, then `lookup_pc` = 0x00400010 → `pred_taken` = 0, `pred_target` = 0x00400014. `mispredict` = 0 and both perf counters = 0.
2. **Allocation:** update at pc 0x00400010, CTI, taken, target 0x00400100, `upd_pred_taken` = 0 → next cycle `mispredict` = 1 and `redirect_addr` = 0x00400100. Lookup 0x00400010 then gives `pred_taken` = 1, `pred_target` = 0x00400100. `perf_cti` = 1, `perf_miss` = 1.
3. **Aliasing:** after scenario 2, lookup 0x00400050 (same index 4, different tag) → `pred_taken` = 0, `pred_target` = 0x00400054. A taken update at 0x00400050 with target 0x00400200 replaces the entry, and 0x00400010 then misses.
4. **Counter hysteresis:** starting from counter 10, issue two not-taken updates (→ 01 → 00), then one taken update (→ 01) → lookup predicts not-taken. Each not-taken update whose pred was taken produces `mispredict` = 1 with `redirect_addr` = pc + 4.
5. **Bypass and wrap:** a taken update and a lookup of the same PC in the same cycle → the lookup returns old data, and the new prediction appears one cycle later. A miss lookup at 0xFFFFFFFC → `pred_target` = 0x00000000.
6. **Saturation and reset:** force `perf_miss` to all-ones (or use PERF_WIDTH = 4 and 16 misses) → the count holds at 0xF. Assert `rst_n` low mid-stream → all outputs and table clear immediately, with no clock edge required.
